// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexed 7-segment driver for a bank of BCD
// digits. A snapshot of all digits is taken once per frame so the display
// never tears; one digit at a time is decoded and its one-hot select held
// for PRESCALE clocks. Supports leading-zero blanking and flags codes > 9.
module bcd_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  lzb,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(PRESCALE - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state, state_n;
  logic [PW-1:0]         pre, pre_n;
  logic [IW-1:0]         idx, idx_n;
  logic [4*DIGITS-1:0]   snap, snap_n;
  logic                  lzb_s, lzb_n;
  logic [6:0]            seg_n;
  logic [DIGITS-1:0]     an_n;
  logic                  err_n;

  // Segment pattern for one BCD code; illegal codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Pattern for digit i of snapshot s, blanked when it and every more
  // significant digit are zero. Digit 0 always shows so "0" stays visible.
  function automatic logic [6:0] display(input logic [4*DIGITS-1:0] s,
                                         input logic                l,
                                         input logic [IW-1:0]       i);
    logic upper_nonzero;
    upper_nonzero = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(i) && s[4*k +: 4] != 4'd0) upper_nonzero = 1'b1;
    end
    if (l && i != '0 && !upper_nonzero) return 7'h00;
    return decode(s[4*int'(i) +: 4]);
  endfunction

  // True when any digit of the word holds a code 10..15.
  function automatic logic any_invalid(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // One-hot digit select for index i.
  function automatic logic [DIGITS-1:0] onehot(input logic [IW-1:0] i);
    logic [DIGITS-1:0] oh;
    for (int k = 0; k < DIGITS; k++) oh[k] = (int'(i) == k);
    return oh;
  endfunction

  // Next-state logic; outputs are computed from the next index/snapshot so
  // the registered seg/an change on the same edge the index moves.
  always_comb begin
    state_n = state;
    pre_n   = pre;
    idx_n   = idx;
    snap_n  = snap;
    lzb_n   = lzb_s;
    err_n   = err;
    seg_n   = 7'h00;
    an_n    = '0;
    case (state)
      IDLE: begin
        pre_n = '0;
        idx_n = '0;
        if (en) begin
          state_n = SCAN;
          snap_n  = bcd;
          lzb_n   = lzb;
          err_n   = any_invalid(bcd);
          an_n    = onehot('0);
          seg_n   = display(bcd, lzb, '0);
        end
      end
      SCAN: begin
        if (!en) begin
          state_n = IDLE;
          pre_n   = '0;
          idx_n   = '0;
        end else begin
          if (pre == LAST_PRE) begin
            pre_n = '0;
            if (idx == LAST_IDX) begin
              idx_n  = '0;
              snap_n = bcd;
              lzb_n  = lzb;
              err_n  = any_invalid(bcd);
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            pre_n = pre + 1'b1;
          end
          an_n  = onehot(idx_n);
          seg_n = display(snap_n, lzb_n, idx_n);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters, snapshot and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pre   <= '0;
      idx   <= '0;
      snap  <= '0;
      lzb_s <= 1'b0;
      seg   <= 7'h00;
      an    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      pre   <= pre_n;
      idx   <= idx_n;
      snap  <= snap_n;
      lzb_s <= lzb_n;
      seg   <= seg_n;
      an    <= an_n;
      err   <= err_n;
    end
  end

endmodule
